// File: rtl/auction_round_ctrl.sv
// auction_round_ctrl: opens a round on start, collects one bid per requester, scans for the max bid,
// and holds the winner on a valid/ready output. Define AUCTION_TIMEOUT_EN to bound COLLECT to TIMEOUT cycles.
module auction_round_ctrl #(
  parameter int bW      = 17,
  parameter int N       = 10,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  bid_valid,
  input  logic [bW-1:0] bids [0:N-1],
  output logic [N-1:0]  bid_ready,
  output logic          busy,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [3:0]    win_idx,
  output logic [bW-1:0] win_bid,
  output logic          win_none
);

  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, ANNOUNCE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  got, got_nxt, xfer;
  logic [bW-1:0] bid_q [0:N-1];
  logic [KW-1:0] k;
  logic [bW-1:0] best_bid, best_bid_nxt;
  logic [3:0]    best_idx, best_idx_nxt;
  logic          found, found_nxt;
  logic          none_nxt;
`ifdef AUCTION_TIMEOUT_EN
  logic [15:0]   to_cnt;
`endif

  always_comb begin
    bid_ready    = (state == COLLECT) ? ~got : '0;
    busy         = (state != IDLE);
    xfer         = bid_valid & bid_ready;
    got_nxt      = got | xfer;
    best_bid_nxt = best_bid;
    best_idx_nxt = best_idx;
    found_nxt    = found;
    none_nxt     = 1'b0;
    state_nxt    = state;

    // Strict compare keeps the lowest index on ties.
    if (state == RESOLVE && got[k] && (!found || bid_q[k] > best_bid)) begin
      best_bid_nxt = bid_q[k];
      best_idx_nxt = 4'(k);
      found_nxt    = 1'b1;
    end

    case (state)
      IDLE:     if (start) state_nxt = COLLECT;
      COLLECT: begin
        if (&got_nxt) state_nxt = RESOLVE;
`ifdef AUCTION_TIMEOUT_EN
        else if (to_cnt == 16'(TIMEOUT - 1)) begin
          if (got_nxt == '0) begin
            state_nxt = ANNOUNCE;
            none_nxt  = 1'b1;
          end else begin
            state_nxt = RESOLVE;
          end
        end
`endif
      end
      RESOLVE:  if (k == KW'(N - 1)) state_nxt = ANNOUNCE;
      ANNOUNCE: if (win_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      got       <= '0;
      k         <= '0;
      best_bid  <= '0;
      best_idx  <= '0;
      found     <= 1'b0;
      win_valid <= 1'b0;
      win_idx   <= '0;
      win_bid   <= '0;
      win_none  <= 1'b0;
      for (int i = 0; i < N; i++) bid_q[i] <= '0;
`ifdef AUCTION_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      win_valid <= (state_nxt == ANNOUNCE);

      case (state)
        IDLE: if (start) begin
          got      <= '0;
          k        <= '0;
          best_bid <= '0;
          best_idx <= '0;
          found    <= 1'b0;
`ifdef AUCTION_TIMEOUT_EN
          to_cnt   <= '0;
`endif
        end
        COLLECT: begin
          got <= got_nxt;
          for (int i = 0; i < N; i++)
            if (xfer[i]) bid_q[i] <= bids[i];
`ifdef AUCTION_TIMEOUT_EN
          to_cnt <= to_cnt + 16'd1;
`endif
        end
        RESOLVE: begin
          k        <= k + KW'(1);
          best_bid <= best_bid_nxt;
          best_idx <= best_idx_nxt;
          found    <= found_nxt;
        end
        default: ;
      endcase

      // Result registers load once on entry to ANNOUNCE, including the final scan step.
      if (state != ANNOUNCE && state_nxt == ANNOUNCE) begin
        win_idx  <= none_nxt ? 4'd0 : best_idx_nxt;
        win_bid  <= none_nxt ? '0 : best_bid_nxt;
        win_none <= none_nxt;
      end
    end
  end

endmodule

// File: tb/tb_auction_round_ctrl.sv
// Directed bench for auction_round_ctrl: full rounds, ties, staggered bids, backpressure, reset, timeout.
module tb_auction_round_ctrl;

  localparam int N  = 10;
  localparam int BW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  bid_valid;
  logic [BW-1:0] bids [0:N-1];
  logic [N-1:0]  bid_ready;
  logic          busy;
  logic          win_valid;
  logic          win_ready;
  logic [3:0]    win_idx;
  logic [BW-1:0] win_bid;
  logic          win_none;

  int nvec = 0;
  int errs = 0;

  auction_round_ctrl #(.bW(BW), .N(N), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bid_valid (bid_valid),
    .bids      (bids),
    .bid_ready (bid_ready),
    .busy      (busy),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_idx   (win_idx),
    .win_bid   (win_bid),
    .win_none  (win_none)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // All bids offered in the first COLLECT cycle; result expected at start+N+2.
  task automatic full_round(input string tag, input int ei, input int eb);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready_open"}, 32'(bid_ready), 32'h3FF);
    bid_valid = '1;
    tick;
    bid_valid = '0;
    chk({tag, "_ready_closed"}, 32'(bid_ready), 32'h0);
    repeat (N - 1) tick;
    chk({tag, "_early_valid"}, 32'(win_valid), 32'd0);
    tick;
    chk({tag, "_valid"}, 32'(win_valid), 32'd1);
    chk({tag, "_idx"}, 32'(win_idx), 32'(ei));
    chk({tag, "_bid"}, 32'(win_bid), 32'(eb));
    chk({tag, "_none"}, 32'(win_none), 32'd0);
    win_ready = 1'b1;
    tick;
    win_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(win_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_idx_held"}, 32'(win_idx), 32'(ei));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    bid_valid = '0;
    win_ready = 1'b0;
    for (int i = 0; i < N; i++) bids[i] = '0;
    tick;
    chk("rst_ready", 32'(bid_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(win_valid), 32'd0);
    chk("rst_idx", 32'(win_idx), 32'd0);
    chk("rst_bid", 32'(win_bid), 32'd0);
    chk("rst_none", 32'(win_none), 32'd0);
    rst = 1'b0;
    tick;

    // Distinct bids, including a zero bid
    bids[0] = 17'd5; bids[1] = 17'd9; bids[2] = 17'd3; bids[3] = 17'd17; bids[4] = 17'd2;
    bids[5] = 17'd8; bids[6] = 17'd1; bids[7] = 17'd0; bids[8] = 17'd4;  bids[9] = 17'd6;
    full_round("distinct", 3, 17);

    // Tie at value 7 on indices 2, 5, 9
    for (int i = 0; i < N; i++) bids[i] = 17'd1;
    bids[2] = 17'd7; bids[5] = 17'd7; bids[9] = 17'd7;
    full_round("tie", 2, 7);

    // Staggered arrivals with bid_valid left high
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      bids[i]      = (i == 9) ? 17'h1FFFF : 17'(100 + i);
      bid_valid[i] = 1'b1;
      tick;
      chk("stag_ready", 32'(bid_ready), 32'(10'h3FF & ~((32'h1 << (i + 1)) - 32'h1)));
    end
    repeat (N - 1) tick;
    chk("stag_early_valid", 32'(win_valid), 32'd0);
    tick;
    chk("stag_valid", 32'(win_valid), 32'd1);
    chk("stag_idx", 32'(win_idx), 32'd9);
    chk("stag_bid", 32'(win_bid), 32'h1FFFF);

    // Backpressure: outputs hold and start is ignored
    for (int c = 0; c < 20; c++) begin
      start = 1'b1;
      tick;
      chk("bp_valid", 32'(win_valid), 32'd1);
      chk("bp_idx", 32'(win_idx), 32'd9);
      chk("bp_bid", 32'(win_bid), 32'h1FFFF);
    end
    start     = 1'b0;
    bid_valid = '0;
    win_ready = 1'b1;
    tick;
    win_ready = 1'b0;
    chk("bp_release_valid", 32'(win_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_ready", 32'(bid_ready), 32'h3FF);

    // Reset during RESOLVE scan step 4
    for (int i = 0; i < N; i++) bids[i] = 17'(i * 3);
    bid_valid = '1;
    tick;
    bid_valid = '0;
    repeat (4) tick;
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(bid_ready), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(win_valid), 32'd0);
    chk("midrst_idx", 32'(win_idx), 32'd0);
    chk("midrst_bid", 32'(win_bid), 32'd0);
    chk("midrst_none", 32'(win_none), 32'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick;
      chk("postrst_no_valid", 32'(win_valid), 32'd0);
    end
    for (int i = 0; i < N; i++) bids[i] = 17'(50 - 5 * i);
    full_round("after_rst", 0, 50);

`ifdef AUCTION_TIMEOUT_EN
    // Partial round closed by timeout
    for (int i = 0; i < N; i++) bids[i] = '0;
    bids[1] = 17'd12;
    bids[6] = 17'd30;
    start = 1'b1;
    tick;
    start     = 1'b0;
    bid_valid = 10'b0001000010;
    tick;
    bid_valid = '0;
    repeat (6) tick;
    chk("to_last_collect_ready", 32'(bid_ready), 32'h3BD);
    tick;
    chk("to_resolve_ready", 32'(bid_ready), 32'h0);
    chk("to_resolve_busy", 32'(busy), 32'd1);
    repeat (N - 1) tick;
    chk("to_early_valid", 32'(win_valid), 32'd0);
    tick;
    chk("to_valid", 32'(win_valid), 32'd1);
    chk("to_idx", 32'(win_idx), 32'd6);
    chk("to_bid", 32'(win_bid), 32'd30);
    chk("to_none", 32'(win_none), 32'd0);
    win_ready = 1'b1;
    tick;
    win_ready = 1'b0;

    // Empty round: no bids at all
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (7) tick;
    chk("empty_last_collect_ready", 32'(bid_ready), 32'h3FF);
    tick;
    chk("empty_valid", 32'(win_valid), 32'd1);
    chk("empty_none", 32'(win_none), 32'd1);
    chk("empty_idx", 32'(win_idx), 32'd0);
    chk("empty_bid", 32'(win_bid), 32'd0);
    win_ready = 1'b1;
    tick;
    win_ready = 1'b0;
    chk("empty_idle_valid", 32'(win_valid), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
